pwm_capture: RTL and testbench

- Receive-side counterpart of the PWM generator. Samples an external PWM line and measures the period and high time of each complete cycle, in clk cycles.
- Publishes each result with a one-cycle valid strobe.
- Flags a stalled line (0% or 100% duty, or a disconnected input) via timeout.
- Sits beside the PWM generator in the peripheral. It is used for loopback self-test and for capturing external PWM inputs.

---
 rtl/pwm_capture.sv | 137 +++++++++++++
 tb/tb_pwm_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM line in clk cycles.
//   clk        - peripheral clock
//   rst        - synchronous, active-high reset
//   cap_en     - capture enable; low returns to IDLE and clears the counter
//   pwm_in     - asynchronous PWM line (double-flop synchronized here)
//   period_out - last measured period (rise to rise), clk cycles
//   high_out   - last measured high time (rise to fall), clk cycles
//   meas_valid - one-cycle strobe, period_out/high_out updated this cycle
//   timeout    - one-cycle strobe, counter reached MAX_CNT with no edge
//   no_signal  - set on timeout, cleared on the next meas_valid or reset
//   level_out  - synchronized line level captured at timeout (1 = stuck high)
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_CNT = 2**CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout,
  output logic             no_signal,
  output logic             level_out
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_q;
  logic             rise;
  logic             fall;

  // Edge detect on the synchronized line; the fixed 3-cycle latency cancels
  // out because both ends of every measurement see the same delay.
  assign rise = s2 & ~p;
  assign fall = ~s2 & p;

  // Synchronizer, measurement FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      p          <= 1'b0;
      cnt        <= '0;
      high_q     <= '0;
      state      <= IDLE;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      no_signal  <= 1'b0;
      level_out  <= 1'b0;
    end else begin
      s1         <= pwm_in;
      s2         <= s1;
      p          <= s2;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      if (!cap_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT_RISE;
          end

          // Partial cycle before the first rise is never reported.
          WAIT_RISE: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= MEAS_HIGH;
            end
          end

          // An edge coinciding with cnt == MAX_CNT wins over the timeout.
          MEAS_HIGH: begin
            if (fall) begin
              high_q <= cnt;
              cnt    <= cnt + CNT_ONE;
              state  <= MEAS_LOW;
            end else if (cnt == CNT_LIMIT) begin
              timeout   <= 1'b1;
              no_signal <= 1'b1;
              level_out <= s2;
              cnt       <= '0;
              state     <= WAIT_RISE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          MEAS_LOW: begin
            if (rise) begin
              period_out <= cnt;
              high_out   <= high_q;
              meas_valid <= 1'b1;
              no_signal  <= 1'b0;
              cnt        <= CNT_ONE;
              state      <= MEAS_HIGH;
            end else if (cnt == CNT_LIMIT) begin
              timeout   <= 1'b1;
              no_signal <= 1'b1;
              level_out <= s2;
              cnt       <= '0;
              state     <= WAIT_RISE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: the stimulus pushes hand-computed
// expected strobes, a forked monitor pops and compares on every strobe.
module tb_pwm_capture;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_CNT = 120;

  logic             clk;
  logic             rst;
  logic             cap_en;
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             timeout;
  logic             no_signal;
  logic             level_out;

  pwm_capture #(.CNT_W(CNT_W), .MAX_CNT(MAX_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .no_signal  (no_signal),
    .level_out  (level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    bit lvl;
    bit chk_gap;
    int gap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_evt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expectation per meas_valid/timeout strobe.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (meas_valid || timeout) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", int'({meas_valid, timeout}), 0);
        end else begin
          e = q.pop_front();
          chk("timeout_strobe", int'(timeout), int'(e.is_to));
          chk("meas_valid_strobe", int'(meas_valid), int'(!e.is_to));
          if (!e.is_to) begin
            chk("period_out", int'(period_out), e.per);
            chk("high_out", int'(high_out), e.hi);
            chk("no_signal_after_meas", int'(no_signal), 0);
          end else begin
            chk("level_out", int'(level_out), int'(e.lvl));
            chk("no_signal_at_timeout", int'(no_signal), 1);
          end
          if (e.chk_gap) chk("strobe_spacing", cyc - last_evt, e.gap);
        end
        last_evt = cyc;
      end
    end
  endtask

  // One high/low pair starting at a negedge; optionally expects the strobe
  // reported by this pair's rise and a timeout inside this pair.
  task automatic pulse(input int h, input int l, input bit exp_m, input int ep,
                       input int eh, input bit gchk, input bit exp_to, input bit lvl);
    exp_t e;
    if (exp_m) begin
      e = '{is_to: 1'b0, per: ep, hi: eh, lvl: 1'b0, chk_gap: gchk, gap: ep};
      q.push_back(e);
    end
    if (exp_to) begin
      e = '{is_to: 1'b1, per: 0, hi: 0, lvl: lvl, chk_gap: 1'b1, gap: int'(MAX_CNT)};
      q.push_back(e);
    end
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic p_none(input int h, input int l);
    pulse(h, l, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic p_meas(input int h, input int l, input int ep, input int eh, input bit gchk);
    pulse(h, l, 1'b1, ep, eh, gchk, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period_out"}, int'(period_out), 0);
    chk({tag, "_high_out"}, int'(high_out), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_no_signal"}, int'(no_signal), 0);
    chk({tag, "_level_out"}, int'(level_out), 0);
  endtask

  initial begin
    rst    = 1'b1;
    cap_en = 1'b0;
    pwm_in = 1'b0;
    fork
      monitor();
    join_none

    // Reset with the line toggling.
    repeat (3) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    @(negedge clk);
    chk_all_zero("reset");
    rst    = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    cap_en = 1'b1;
    repeat (5) @(negedge clk);

    // Steady 30/70: first strobe follows the second rise.
    p_none(30, 70);
    p_meas(30, 70, 100, 30, 1'b0);
    p_meas(30, 70, 100, 30, 1'b1);
    p_meas(30, 70, 100, 30, 1'b1);

    // Switch to 5/3, then one mixed 30/3 period.
    p_meas(5, 3, 100, 30, 1'b1);
    p_meas(5, 3, 8, 5, 1'b1);
    p_meas(5, 3, 8, 5, 1'b1);
    p_meas(5, 3, 8, 5, 1'b1);
    p_meas(30, 3, 8, 5, 1'b1);
    p_meas(5, 3, 33, 30, 1'b1);

    // Extreme duty 1/1.
    p_meas(1, 1, 8, 5, 1'b1);
    p_meas(1, 1, 2, 1, 1'b1);
    p_meas(1, 1, 2, 1, 1'b1);
    p_meas(1, 1, 2, 1, 1'b1);

    // Period of exactly MAX_CNT: rise at the limit beats the timeout.
    p_meas(30, 90, 2, 1, 1'b1);
    p_meas(4, 6, 120, 30, 1'b1);
    p_meas(4, 6, 10, 4, 1'b1);

    // Stuck high: timeout MAX_CNT cycles after the reporting strobe.
    pulse(150, 10, 1'b1, 10, 4, 1'b1, 1'b1, 1'b1);
    p_none(4, 6);
    chk("no_signal_held", int'(no_signal), 1);
    p_meas(4, 6, 10, 4, 1'b0);

    // Stuck low.
    pulse(4, 200, 1'b1, 10, 4, 1'b1, 1'b1, 1'b0);
    p_none(4, 6);
    p_meas(4, 6, 10, 4, 1'b0);

    // Drop cap_en during MEAS_LOW; outputs hold while disabled.
    p_meas(4, 6, 10, 4, 1'b1);
    cap_en = 1'b0;
    p_none(2, 2);
    p_none(2, 2);
    p_none(2, 2);
    repeat (10) @(negedge clk);
    chk("hold_period_out", int'(period_out), 10);
    chk("hold_high_out", int'(high_out), 4);
    chk("hold_no_signal", int'(no_signal), 0);
    chk("hold_level_out", int'(level_out), 0);
    cap_en = 1'b1;
    repeat (3) @(negedge clk);
    p_none(4, 6);
    p_meas(3, 7, 10, 4, 1'b0);
    p_meas(2, 2, 10, 3, 1'b1);
    p_meas(4, 20, 4, 2, 1'b1);

    // Reset mid-measurement clears everything.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    p_none(4, 6);
    p_meas(4, 6, 10, 4, 1'b0);

    repeat (20) @(negedge clk);
    chk("pending_expectations", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
